// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - handshake bundle for the sequential binary-to-BCD converter
//
// Signals:
//   bin_in    : unsigned binary value to convert (producer -> converter)
//   in_valid  : bin_in is valid this cycle (producer -> converter)
//   in_ready  : converter can accept a new value (converter -> producer)
//   bcd_out   : packed BCD result, [3:0] units, [7:4] tens, ... (converter -> consumer)
//   out_valid : one-cycle strobe, bcd_out updated this cycle (converter -> consumer)
//   busy      : conversion in progress (converter -> consumer)
// Modports: master = producer/consumer side, slave = converter side.

interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) ();

    logic [BIN_W-1:0]    bin_in;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                out_valid;
    logic                busy;

    modport master (
        output bin_in,
        output in_valid,
        input  in_ready,
        input  bcd_out,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  bin_in,
        input  in_valid,
        output in_ready,
        output bcd_out,
        output out_valid,
        output busy
    );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary to packed BCD converter
//
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active-high
//   bus : bin_to_bcd_seq_if.slave
//         bin_in/in_valid/in_ready : input handshake, accepted only in IDLE
//         bcd_out                  : last completed result, held until next DONE
//         out_valid                : one-cycle strobe while in DONE
//         busy                     : high whenever state != IDLE
//
// One binary bit is consumed per SHIFT cycle, so a conversion takes BIN_W
// SHIFT cycles plus one DONE cycle; the next value can be accepted on the
// edge after DONE, giving one result every BIN_W+2 cycles.

module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int SCR_W  = 4 * DIGITS;
    localparam int WORD_W = SCR_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // DIGITS decimal digits must cover the largest BIN_W-bit value, otherwise
    // the top scratch bit would be shifted out and the result truncated.
    function automatic bit digits_ok();
        longint pow10;
        longint max_bin;
        pow10 = 1;
        for (int i = 0; i < DIGITS; i++) begin
            pow10 = pow10 * 10;
        end
        max_bin = (longint'(1) << BIN_W) - 1;
        return pow10 > max_bin;
    endfunction

    localparam bit DIGITS_OK = digits_ok();

    generate
        if (!DIGITS_OK) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic [BIN_W-1:0] bin_sr;
    logic [SCR_W-1:0] scratch;
    logic [CNT_W-1:0] cnt;
    logic [SCR_W-1:0] bcd_q;

    logic [SCR_W-1:0]  scratch_adj;
    logic [WORD_W-1:0] shift_word;
    logic [SCR_W-1:0]  scratch_next;
    logic [BIN_W-1:0]  bin_next;

    logic in_ready_c;
    logic busy_c;
    logic out_valid_c;

    // Add-3 correction on every nibble that would reach >= 10 after doubling.
    // Each nibble uses its own pre-shift value; a corrected nibble is at most
    // 9+3 = 12 and never carries into its neighbour.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // {scratch, binary} move left together: the binary MSB enters the units
    // nibble's LSB.
    always_comb begin
        shift_word   = {scratch_adj, bin_sr} << 1;
        scratch_next = shift_word[WORD_W-1 -: SCR_W];
        bin_next     = shift_word[BIN_W-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // cnt == 1 means this edge performs the final shift.
                if (cnt == CNT_ONE) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output logic, decoded from state only.
    always_comb begin
        in_ready_c  = 1'b0;
        busy_c      = 1'b1;
        out_valid_c = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
            end
            S_DONE: begin
                out_valid_c = 1'b1;
            end
            default: begin
                in_ready_c  = 1'b0;
                busy_c      = 1'b1;
                out_valid_c = 1'b0;
            end
        endcase
    end

    // Datapath. bcd_q is only written on the last shift so the output never
    // exposes partial scratch contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        bin_sr  <= bus.bin_in;
                        scratch <= '0;
                        cnt     <= CNT_LOAD;
                    end
                end
                S_SHIFT: begin
                    bin_sr  <= bin_next;
                    scratch <= scratch_next;
                    cnt     <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        bcd_q <= scratch_next;
                    end
                end
                default: begin
                    bin_sr  <= bin_sr;
                    scratch <= scratch;
                    cnt     <= cnt;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.out_valid = out_valid_c;
    assign bus.bcd_out   = bcd_q;

endmodule
